// File: rtl/icache_assoc.sv
// Set-associative instruction cache with true-LRU replacement, whole-block
// refill from memory, synchronous flush and saturating hit/miss counters.
module icache_assoc #(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned OB = $clog2(BLOCK_WORDS);
  localparam int unsigned IB = $clog2(SETS);
  localparam int unsigned AB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned OW = (OB > 0) ? OB : 1;
  localparam int unsigned TW = 32 - 2 - OB - IB;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  // Storage
  logic          valid_q [WAYS][SETS];
  logic          valid_d [WAYS][SETS];
  logic [TW-1:0] tag_q   [WAYS][SETS];
  logic [TW-1:0] tag_d   [WAYS][SETS];
  logic [31:0]   data_q  [WAYS][SETS][BLOCK_WORDS];
  logic [31:0]   data_d  [WAYS][SETS][BLOCK_WORDS];
  logic [AB-1:0] age_q   [SETS][WAYS];
  logic [AB-1:0] age_d   [SETS][WAYS];

  // Control
  state_e        state_q, state_d;
  logic [OW-1:0] k_q, k_d;
  logic [TW-1:0] ftag_q, ftag_d;
  logic [IB-1:0] fidx_q, fidx_d;
  logic [AB-1:0] vict_q, vict_d;
  logic [31:0]   hit_count_q, hit_count_d;
  logic [31:0]   miss_count_q, miss_count_d;

  // Request decode and lookup results
  logic [OW-1:0] req_off;
  logic [IB-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          match;
  logic [AB-1:0] hit_way;
  logic [AB-1:0] vict_sel;
  logic          inv_found;
  logic          touch_en;
  logic [IB-1:0] touch_set;
  logic [AB-1:0] touch_way;

  // Split the fetch address into offset, index and tag
  always_comb begin
    req_off = OW'((imemaddr >> 2) & 32'(BLOCK_WORDS - 1));
    req_idx = IB'(imemaddr >> (2 + OB));
    req_tag = TW'(imemaddr >> (2 + OB + IB));
  end

  // Tag compare across the ways of the addressed set; flush masks the hit
  always_comb begin
    match   = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        match   = 1'b1;
        hit_way = AB'(w);
      end
    end
    ihit     = imemREN && (state_q == IDLE) && match && !flush;
    imemload = ihit ? data_q[hit_way][req_idx][req_off] : '0;
  end

  // Victim: lowest invalid way, else the oldest way
  always_comb begin
    vict_sel  = '0;
    inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[w][req_idx]) begin
        inv_found = 1'b1;
        vict_sel  = AB'(w);
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[req_idx][w] == AB'(WAYS - 1)) vict_sel = AB'(w);
      end
    end
  end

  // Memory request is a pure decode of the fill registers
  always_comb begin
    iREN  = (state_q == FILL);
    iaddr = '0;
    if (state_q == FILL) begin
      iaddr = (32'(ftag_q) << (2 + OB + IB)) | (32'(fidx_q) << (2 + OB)) | (32'(k_q) << 2);
    end
  end

  // Next-state: flush, hit bookkeeping, miss entry and block refill
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    ftag_d       = ftag_q;
    fidx_d       = fidx_q;
    vict_d       = vict_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    age_d        = age_q;
    touch_en     = 1'b0;
    touch_set    = '0;
    touch_way    = '0;

    if (flush) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_d[w][s] = 1'b0;
          age_d[s][w]   = AB'(w);
        end
      end
      state_d = IDLE;
      k_d     = '0;
    end else begin
      if (ihit) begin
        touch_en    = 1'b1;
        touch_set   = req_idx;
        touch_way   = hit_way;
        hit_count_d = (hit_count_q == '1) ? hit_count_q : hit_count_q + 32'd1;
      end
      case (state_q)
        IDLE: begin
          if (imemREN && !ihit) begin
            state_d      = FILL;
            k_d          = '0;
            ftag_d       = req_tag;
            fidx_d       = req_idx;
            vict_d       = vict_sel;
            miss_count_d = (miss_count_q == '1) ? miss_count_q : miss_count_q + 32'd1;
          end
        end
        FILL: begin
          if (!iwait) begin
            data_d[vict_q][fidx_q][k_q] = iload;
            if (k_q == OW'(BLOCK_WORDS - 1)) begin
              valid_d[vict_q][fidx_q] = 1'b1;
              tag_d[vict_q][fidx_q]   = ftag_q;
              touch_en  = 1'b1;
              touch_set = fidx_q;
              touch_way = vict_q;
              state_d   = IDLE;
              k_d       = '0;
            end else begin
              k_d = k_q + OW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Make touched way MRU; ways younger than it age by one
    if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AB'(w) == touch_way) begin
          age_d[touch_set][w] = '0;
        end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
          age_d[touch_set][w] = age_q[touch_set][w] + AB'(1);
        end
      end
    end
  end

  // Control, tag, valid and age registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      k_q          <= '0;
      ftag_q       <= '0;
      fidx_q       <= '0;
      vict_q       <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          tag_q[w][s]   <= '0;
          age_q[s][w]   <= AB'(w);
        end
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      ftag_q       <= ftag_d;
      fidx_q       <= fidx_d;
      vict_q       <= vict_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      age_q        <= age_d;
    end
  end

  // Data array needs no reset; valid bits guard it
  always_ff @(posedge CLK) begin
    data_q <= data_d;
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default parameters (8 sets, 2 ways, 2 words).
module tb_icache_assoc;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int errors;
  int checks;
  int exp_hit;
  int exp_miss;

  icache_assoc dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .flush      (flush),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: word at address A holds A ^ 0xFFFF0000
  assign iload = iaddr ^ 32'hFFFF0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // exp_cyc = 0: expect same-cycle hit; otherwise expect ihit after exp_cyc cycles
  task automatic access(input logic [31:0] a, input int exp_cyc);
    int n;
    imemaddr = a;
    imemREN  = 1'b1;
    #1;
    if (exp_cyc == 0) begin
      chk($sformatf("hit_%h", a), 32'(ihit), 32'd1);
    end else begin
      chk($sformatf("miss_%h", a), 32'(ihit), 32'd0);
      n = 0;
      do begin
        tick();
        n++;
      end while (ihit !== 1'b1 && n < 40);
      chk($sformatf("latency_%h", a), 32'(n), 32'(exp_cyc));
      exp_miss++;
    end
    chk($sformatf("load_%h", a), imemload, a ^ 32'hFFFF0000);
    tick();
    exp_hit++;
    imemREN = 1'b0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_hits"}, hit_count, 32'(exp_hit));
    chk({tag, "_misses"}, miss_count, 32'(exp_miss));
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    exp_hit  = 0;
    exp_miss = 0;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    flush    = 1'b0;
    iwait    = 1'b0;

    // Reset values
    #3;
    chk("rst_iREN", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk_counters("rst");
    tick();
    nRST = 1'b1;
    tick();

    // First miss: iREN for two cycles at 0x40 then 0x44, hit on third cycle
    imemaddr = 32'h40;
    imemREN  = 1'b1;
    #1;
    chk("s1_miss", 32'(ihit), 32'd0);
    chk("s1_idle_iREN", 32'(iREN), 32'd0);
    tick();
    chk("s1_iREN_1", 32'(iREN), 32'd1);
    chk("s1_iaddr_1", iaddr, 32'h40);
    chk("s1_nohit_1", 32'(ihit), 32'd0);
    tick();
    chk("s1_iREN_2", 32'(iREN), 32'd1);
    chk("s1_iaddr_2", iaddr, 32'h44);
    tick();
    chk("s1_hit", 32'(ihit), 32'd1);
    chk("s1_load", imemload, 32'hFFFF0040);
    chk("s1_iREN_done", 32'(iREN), 32'd0);
    chk("s1_iaddr_done", iaddr, 32'd0);
    tick();
    exp_hit++;
    exp_miss++;
    access(32'h44, 0);
    chk("s1_hit_count", hit_count, 32'd2);
    chk("s1_miss_count", miss_count, 32'd1);

    // Same-set conflict: 0x040 is LRU once 0x000 is touched, so 0x080 evicts it
    access(32'h000, 3);
    access(32'h040, 0);
    access(32'h000, 0);
    access(32'h080, 3);
    access(32'h000, 0);
    access(32'h040, 3);
    chk_counters("s2");

    // Memory wait: three wait cycles before each word, address held steady
    imemaddr = 32'hC8;
    imemREN  = 1'b1;
    iwait    = 1'b1;
    #1;
    chk("s3_miss", 32'(ihit), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      iwait = (c % 4 == 0) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("s3_iREN_c%0d", c), 32'(iREN), 32'd1);
      chk($sformatf("s3_iaddr_c%0d", c), iaddr, (c <= 4) ? 32'hC8 : 32'hCC);
      chk($sformatf("s3_nohit_c%0d", c), 32'(ihit), 32'd0);
    end
    tick();
    chk("s3_hit_c9", 32'(ihit), 32'd1);
    chk("s3_load", imemload, 32'hFFFF00C8);
    iwait = 1'b0;
    tick();
    imemREN = 1'b0;
    exp_hit++;
    exp_miss++;
    access(32'hCC, 0);
    chk_counters("s3");

    // Address change mid-fill, from a fresh reset
    #1;
    nRST = 1'b0;
    #1;
    nRST     = 1'b1;
    exp_hit  = 0;
    exp_miss = 0;
    imemaddr = 32'h100;
    imemREN  = 1'b1;
    #1;
    chk("s4_miss", 32'(ihit), 32'd0);
    tick();
    chk("s4_iaddr_1", iaddr, 32'h100);
    imemaddr = 32'h200;
    #1;
    chk("s4_iaddr_1_held", iaddr, 32'h100);
    chk("s4_nohit_fill", 32'(ihit), 32'd0);
    tick();
    chk("s4_iaddr_2", iaddr, 32'h104);
    tick();
    chk("s4_iREN_idle", 32'(iREN), 32'd0);
    chk("s4_second_miss", 32'(ihit), 32'd0);
    tick();
    chk("s4_iaddr_3", iaddr, 32'h200);
    tick();
    chk("s4_iaddr_4", iaddr, 32'h204);
    tick();
    chk("s4_hit_200", 32'(ihit), 32'd1);
    chk("s4_load_200", imemload, 32'hFFFF0200);
    tick();
    imemREN = 1'b0;
    exp_hit  = 1;
    exp_miss = 2;
    chk("s4_miss_count", miss_count, 32'd2);
    access(32'h104, 0);
    chk_counters("s4");

    // Flush after hits: flush masks a would-be hit and leaves counters alone
    imemaddr = 32'h100;
    imemREN  = 1'b1;
    flush    = 1'b1;
    #1;
    chk("s5_flush_masks_hit", 32'(ihit), 32'd0);
    tick();
    flush   = 1'b0;
    imemREN = 1'b0;
    chk_counters("s5_after_flush");
    access(32'h100, 3);
    access(32'h200, 3);

    // Flush during the second word of a fill: block stays invalid
    imemaddr = 32'h300;
    imemREN  = 1'b1;
    #1;
    chk("s5b_miss", 32'(ihit), 32'd0);
    tick();
    chk("s5b_iaddr_1", iaddr, 32'h300);
    tick();
    chk("s5b_iaddr_2", iaddr, 32'h304);
    flush   = 1'b1;
    imemREN = 1'b0;
    tick();
    flush = 1'b0;
    exp_miss++;
    chk("s5b_abort_iREN", 32'(iREN), 32'd0);
    chk_counters("s5b_after_flush");
    access(32'h300, 3);
    access(32'h304, 0);

    // Async reset between edges mid-fill
    imemaddr = 32'h400;
    imemREN  = 1'b1;
    tick();
    chk("s6_iREN_fill", 32'(iREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("s6_iREN_drop", 32'(iREN), 32'd0);
    chk("s6_iaddr_drop", iaddr, 32'd0);
    chk("s6_ihit", 32'(ihit), 32'd0);
    exp_hit  = 0;
    exp_miss = 0;
    chk_counters("s6_reset");
    imemREN = 1'b0;
    #1;
    nRST = 1'b1;
    tick();
    access(32'h400, 3);
    access(32'h300, 3);
    chk_counters("s6_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
